// File: rtl/mp5_addr_map.sv
// Phantom-slot address map for one mp5_stage.
// Converts real packets whose phantom reserved a slot into inserts.
package mp5_pkg;
  typedef struct packed {
    logic        is_phantom;
    logic [7:0]  pipeline;
    logic [15:0] id;
    logic [31:0] data;
  } packet_t;
endpackage

module mp5_addr_map
  import mp5_pkg::*;
#(
  parameter int NUM_PIPELINES = 4,
  parameter int FIFO_SIZE     = 8,
  parameter int MAP_DEPTH     = 16,
  parameter int CNT_W         = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pkt_valid_in,
  input  packet_t                          pkt_in,
  input  logic                             rec_valid,
  input  logic [15:0]                      rec_id,
  input  logic [$clog2(FIFO_SIZE)-1:0]     rec_addr,
  input  logic [$clog2(NUM_PIPELINES)-1:0] rec_fifo,
  output packet_t                          pkt_out,
  output logic [$clog2(NUM_PIPELINES)-1:0] fifo_id_out,
  output logic                             push_out,
  output logic                             insert_out,
  output logic [$clog2(FIFO_SIZE)-1:0]     addr_out,
  output logic                             map_full,
  output logic [CNT_W-1:0]                 hit_cnt,
  output logic [CNT_W-1:0]                 miss_cnt,
  output logic [CNT_W-1:0]                 ovf_cnt
);

  localparam int FW = $clog2(NUM_PIPELINES);
  localparam int AW = $clog2(FIFO_SIZE);
  localparam int IW = $clog2(MAP_DEPTH);

  logic [MAP_DEPTH-1:0] r_vld;
  logic [15:0]          r_id   [MAP_DEPTH];
  logic [AW-1:0]        r_addr [MAP_DEPTH];
  logic [FW-1:0]        r_fifo [MAP_DEPTH];

  logic                 w_real;
  logic                 w_hit;
  logic [IW-1:0]        w_hit_idx;
  logic [MAP_DEPTH-1:0] w_vld_mid;
  logic                 w_rec_match;
  logic [IW-1:0]        w_match_idx;
  logic                 w_free;
  logic [IW-1:0]        w_free_idx;
  logic                 w_rec_wr;
  logic [IW-1:0]        w_rec_idx;
  logic                 w_ovf;
  logic [MAP_DEPTH-1:0] w_vld_nxt;

  assign w_real = pkt_valid_in && !pkt_in.is_phantom;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < MAP_DEPTH; i++) begin
      if (w_real && r_vld[i] && r_id[i] == pkt_in.id) begin
        w_hit     = 1'b1;
        w_hit_idx = IW'(i);
      end
    end
  end

  // Records see the map after this cycle's hit has been consumed.
  always_comb begin
    w_vld_mid = r_vld;
    if (w_hit) w_vld_mid[w_hit_idx] = 1'b0;
  end

  always_comb begin
    w_rec_match = 1'b0;
    w_match_idx = '0;
    w_free      = 1'b0;
    w_free_idx  = '0;
    for (int i = 0; i < MAP_DEPTH; i++) begin
      if (w_vld_mid[i] && r_id[i] == rec_id) begin
        w_rec_match = 1'b1;
        w_match_idx = IW'(i);
      end
    end
    for (int i = MAP_DEPTH - 1; i >= 0; i--) begin
      if (!w_vld_mid[i]) begin
        w_free     = 1'b1;
        w_free_idx = IW'(i);
      end
    end
  end

  always_comb begin
    w_rec_wr  = rec_valid && (w_rec_match || w_free);
    w_rec_idx = w_rec_match ? w_match_idx : w_free_idx;
    w_ovf     = rec_valid && !w_rec_match && !w_free;
    w_vld_nxt = w_vld_mid;
    if (w_rec_wr) w_vld_nxt[w_rec_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < MAP_DEPTH; i++) begin
        r_id[i]   <= '0;
        r_addr[i] <= '0;
        r_fifo[i] <= '0;
      end
    end else begin
      r_vld <= w_vld_nxt;
      if (w_rec_wr) begin
        r_id[w_rec_idx]   <= rec_id;
        r_addr[w_rec_idx] <= rec_addr;
        r_fifo[w_rec_idx] <= rec_fifo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_out     <= '0;
      fifo_id_out <= '0;
      push_out    <= 1'b0;
      insert_out  <= 1'b0;
      addr_out    <= '0;
      map_full    <= 1'b0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      ovf_cnt     <= '0;
    end else begin
      push_out   <= 1'b0;
      insert_out <= 1'b0;
      map_full   <= &w_vld_nxt;
      if (pkt_valid_in) begin
        pkt_out <= pkt_in;
        if (w_hit) begin
          insert_out  <= 1'b1;
          fifo_id_out <= r_fifo[w_hit_idx];
          addr_out    <= r_addr[w_hit_idx];
        end else begin
          push_out    <= 1'b1;
          fifo_id_out <= pkt_in.pipeline[FW-1:0];
          addr_out    <= '0;
        end
      end
      if (w_hit && hit_cnt != '1)
        hit_cnt <= hit_cnt + 1'b1;
      if (w_real && !w_hit && miss_cnt != '1)
        miss_cnt <= miss_cnt + 1'b1;
      if (w_ovf && ovf_cnt != '1)
        ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mp5_addr_map.sv
// Scoreboard bench for mp5_addr_map.
// Reference map is an id-keyed associative array with a depth cap.
module tb_mp5_addr_map;
  import mp5_pkg::*;

  localparam int DEPTH = 16;
  localparam int CMAX  = 65535;

  logic        clk = 1'b0;
  logic        rst;
  logic        pkt_valid_in;
  packet_t     pkt_in;
  logic        rec_valid;
  logic [15:0] rec_id;
  logic [2:0]  rec_addr;
  logic [1:0]  rec_fifo;
  packet_t     pkt_out;
  logic [1:0]  fifo_id_out;
  logic        push_out;
  logic        insert_out;
  logic [2:0]  addr_out;
  logic        map_full;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
  logic [15:0] ovf_cnt;

  mp5_addr_map dut (
    .clk          (clk),
    .rst          (rst),
    .pkt_valid_in (pkt_valid_in),
    .pkt_in       (pkt_in),
    .rec_valid    (rec_valid),
    .rec_id       (rec_id),
    .rec_addr     (rec_addr),
    .rec_fifo     (rec_fifo),
    .pkt_out      (pkt_out),
    .fifo_id_out  (fifo_id_out),
    .push_out     (push_out),
    .insert_out   (insert_out),
    .addr_out     (addr_out),
    .map_full     (map_full),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt),
    .ovf_cnt      (ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic        ins;
    logic [1:0]  fifo;
    logic [2:0]  addr;
    logic [15:0] id;
  } exp_t;

  exp_t q[$];
  int   m_addr[int];
  int   m_fifo[int];
  int   e_hit, e_miss, e_ovf;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic cyc(input bit pv, input bit ph, input int pipe,
                     input int id, input bit rv, input int rid,
                     input int raddr, input int rfifo);
    exp_t e;
    pkt_valid_in    = pv;
    pkt_in          = '0;
    pkt_in.is_phantom = ph;
    pkt_in.pipeline = 8'(pipe);
    pkt_in.id       = 16'(id);
    pkt_in.data     = 32'(id * 7 + 1);
    rec_valid       = rv;
    rec_id          = 16'(rid);
    rec_addr        = 3'(raddr);
    rec_fifo        = 2'(rfifo);
    if (pv) begin
      e = '{1'b1, 1'b0, 2'(pipe), 3'd0, 16'(id)};
      if (!ph && m_addr.exists(id)) begin
        e.push = 1'b0;
        e.ins  = 1'b1;
        e.fifo = 2'(m_fifo[id]);
        e.addr = 3'(m_addr[id]);
        m_addr.delete(id);
        m_fifo.delete(id);
        e_hit = sat(e_hit);
      end else if (!ph) begin
        e_miss = sat(e_miss);
      end
      q.push_back(e);
    end
    if (rv) begin
      if (m_addr.exists(rid) || m_addr.num() < DEPTH) begin
        m_addr[rid] = raddr;
        m_fifo[rid] = rfifo;
      end else begin
        e_ovf = sat(e_ovf);
      end
    end
    @(posedge clk);
    #1;
    if (pv) begin
      e = q.pop_front();
      chk("push", 32'(push_out), 32'(e.push));
      chk("insert", 32'(insert_out), 32'(e.ins));
      chk("fifo_id", 32'(fifo_id_out), 32'(e.fifo));
      chk("addr", 32'(addr_out), 32'(e.addr));
      chk("pkt_id", 32'(pkt_out.id), 32'(e.id));
    end else begin
      chk("idle_push", 32'(push_out), 32'd0);
      chk("idle_insert", 32'(insert_out), 32'd0);
    end
    chk("map_full", 32'(map_full), 32'(m_addr.num() == DEPTH));
    chk("hit_cnt", 32'(hit_cnt), 32'(e_hit));
    chk("miss_cnt", 32'(miss_cnt), 32'(e_miss));
    chk("ovf_cnt", 32'(ovf_cnt), 32'(e_ovf));
  endtask

  task automatic real_pkt(input int pipe, input int id);
    cyc(1, 0, pipe, id, 0, 0, 0, 0);
  endtask

  task automatic rec(input int rid, input int raddr, input int rfifo);
    cyc(0, 0, 0, 0, 1, rid, raddr, rfifo);
  endtask

  task automatic do_reset(input bit pv);
    rst          = 1'b1;
    pkt_valid_in = pv;
    pkt_in       = '0;
    pkt_in.id    = 16'd100;
    pkt_in.pipeline = 8'd3;
    rec_valid    = 1'b0;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    pkt_valid_in = 1'b0;
    m_addr.delete();
    m_fifo.delete();
    q.delete();
    e_hit  = 0;
    e_miss = 0;
    e_ovf  = 0;
    chk("rst_push", 32'(push_out), 32'd0);
    chk("rst_insert", 32'(insert_out), 32'd0);
    chk("rst_fifo", 32'(fifo_id_out), 32'd0);
    chk("rst_addr", 32'(addr_out), 32'd0);
    chk("rst_pkt", 32'(pkt_out.id), 32'd0);
    chk("rst_full", 32'(map_full), 32'd0);
    chk("rst_hit", 32'(hit_cnt), 32'd0);
    chk("rst_miss", 32'(miss_cnt), 32'd0);
    chk("rst_ovf", 32'(ovf_cnt), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    pkt_valid_in = 1'b0;
    pkt_in       = '0;
    rec_valid    = 1'b0;
    rec_id       = '0;
    rec_addr     = '0;
    rec_fifo     = '0;
    e_hit  = 0;
    e_miss = 0;
    e_ovf  = 0;
    @(posedge clk);
    #1;
    do_reset(1'b0);

    cyc(1, 1, 2, 5, 0, 0, 0, 0);

    rec(5, 3, 1);
    real_pkt(0, 5);
    real_pkt(0, 5);

    for (int i = 0; i < 16; i++) rec(i, i % 8, i % 4);
    rec(20, 1, 1);
    real_pkt(1, 20);
    real_pkt(2, 7);

    rec(9, 2, 0);
    rec(9, 6, 3);
    real_pkt(0, 9);
    real_pkt(1, 9);

    rec(4, 1, 2);
    cyc(1, 0, 3, 4, 1, 4, 5, 1);
    real_pkt(3, 4);

    cyc(1, 0, 1, 3, 1, 30, 7, 2);
    real_pkt(2, 30);
    cyc(1, 1, 1, 11, 1, 11, 4, 0);

    do_reset(1'b0);
    for (int i = 0; i < 10; i++) rec(100 + i, i % 8, 3 - (i % 4));
    real_pkt(0, 103);
    do_reset(1'b1);
    real_pkt(1, 100);
    real_pkt(2, 101);
    real_pkt(3, 109);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      int id_r;
      int id_p;
      id_r = int'($urandom_range(0, 24));
      id_p = int'($urandom_range(0, 24));
      cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0),
          int'($urandom_range(0, 3)), id_p,
          bit'($urandom_range(0, 1)), id_r,
          int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mp5_addr_map.md
Name: mp5_addr_map

Overview:
- Sits directly upstream of each mp5_stage and drives its packet, fifo_id_in, push_in, insert_in and addr_in inputs.
- Records the FIFO slot reported by the stage for each phantom packet, in an ID-indexed associative map.
- When the matching real packet arrives, it is converted into an insert into the reserved slot; all other packets become plain pushes.
- One instance per stage.

Parameters:
- NUM_PIPELINES, 4, number of pipelines and per-stage FIFOs (power of 2).
- FIFO_SIZE, 8, stage FIFO depth (power of 2); sets the address width.
- MAP_DEPTH, 16, number of outstanding phantom reservations the map holds.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- pkt_valid_in  input  1  pkt_in carries a packet this cycle.
- pkt_in  input  Packet  incoming packet from upstream.
- rec_valid  input  1  stage reports a phantom placement this cycle.
- rec_id  input  16  phantom id (stage pkt_id_out).
- rec_addr  input  $clog2(FIFO_SIZE)  slot address (stage pkt_addr_out).
- rec_fifo  input  $clog2(NUM_PIPELINES)  FIFO the phantom was pushed into.
- pkt_out  output  Packet  packet to stage.
- fifo_id_out  output  $clog2(NUM_PIPELINES)  target FIFO for push/insert.
- push_out  output  1  push request to stage.
- insert_out  output  1  insert request to stage.
- addr_out  output  $clog2(FIFO_SIZE)  insert slot address.
- map_full  output  1  all MAP_DEPTH entries valid.
- hit_cnt  output  CNT_W  real packets converted to inserts.
- miss_cnt  output  CNT_W  real packets with no reservation (pushed).
- ovf_cnt  output  CNT_W  records dropped because the map was full.

Behaviour:
- Reset:
  - All map entries invalid; all outputs 0, counters 0, map_full 0.
  - Reset mid-operation discards every reservation and any in-flight output.
- Map entry fields: valid, id[15:0], addr, fifo.
- Latency:
  - Exactly 1 cycle from pkt_valid_in to push_out/insert_out; all outputs are registered.
  - No backpressure.
  - Idle cycle: push_out=0, insert_out=0; pkt_out, fifo_id_out and addr_out hold their last values.
- Classification of an accepted pkt_in, using the map state from the start of the cycle:
  - is_phantom=1: push_out=1, fifo_id_out=pkt_in.pipeline, addr_out=0; the map is unchanged.
  - is_phantom=0 and a valid entry has id==pkt_in.id (hit):
    - insert_out=1, fifo_id_out=entry.fifo, addr_out=entry.addr.
    - The entry is invalidated; hit_cnt+1.
  - is_phantom=0 with no match (miss): push_out=1, fifo_id_out=pkt_in.pipeline; miss_cnt+1.
  - push_out and insert_out are never both 1.
- Record port (rec_valid=1):
  - If a valid entry already has id==rec_id, that entry's addr/fifo are overwritten; no new allocation.
  - Otherwise the lowest-index invalid entry is allocated.
  - If no entry is free, the record is dropped and ovf_cnt+1.
- Same cycle, hit on id X and record of id X:
  - The hit consumes the old entry.
  - The record then allocates a fresh entry (the record is applied after the invalidation).
- Same cycle, record and a hit on a different id: both take effect; the record may reuse the entry freed by the hit in that cycle.
- map_full is registered: 1 when all entries are valid after the cycle's updates.
- Counters saturate at 2^CNT_W-1.
- Multiple valid entries never share an id (guaranteed by the overwrite rule); a hit therefore matches at most one entry.

Test Plan:
- Reset, then pkt_in{is_phantom=1, pipeline=2, id=5} valid -> next cycle push_out=1, fifo_id_out=2, insert_out=0; map empty, map_full=0.
- rec_valid{id=5, addr=3, fifo=1}, then real pkt id=5, pipeline=0 -> insert_out=1, fifo_id_out=1, addr_out=3, hit_cnt=1; then a second pkt id=5 -> push_out=1, fifo_id_out=0, miss_cnt=1.
- 16 records with ids 0..15 -> map_full=1; 17th record id=20 -> ovf_cnt=1; real pkt id=20 -> push (miss); real pkt id=7 -> insert, map_full=0.
- Record id=9 addr=2, then record id=9 addr=6 -> only one entry valid; real pkt id=9 -> addr_out=6; next id=9 -> miss.
- Record id=4 addr=1; same cycle as real pkt id=4 arrives, record id=4 addr=5 -> output insert addr_out=1; next real pkt id=4 -> insert addr_out=5.
- Fill 10 entries, assert rst for 1 cycle mid-stream with pkt_valid_in=1 -> outputs 0 the next cycle, counters 0, previously recorded ids now miss.
